// File: rtl/serialize_word_to_bits_if.sv
// Handshake bundle for the word-to-bit serializer: a parallel word input
// and a serial bit output with an end-of-word marker.
interface serialize_word_to_bits_if #(
  parameter int WIDTH = 8
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_data;
  logic             out_valid;
  logic             out_bit;
  logic             out_last;

  modport master (
    output in_valid,
    output in_data,
    input  in_ready,
    input  out_valid,
    input  out_bit,
    input  out_last
  );

  modport slave (
    input  in_valid,
    input  in_data,
    output in_ready,
    output out_valid,
    output out_bit,
    output out_last
  );
endinterface

// File: rtl/serialize_word_to_bits.sv
// Serializes WIDTH-bit words into a one-bit-per-clock stream. A single holding
// register lets the next word queue up so back-to-back words come out gapless.
module serialize_word_to_bits #(
  parameter int WIDTH     = 8,
  parameter bit MSB_FIRST = 1'b1,
  parameter bit IDLE_BIT  = 1'b0
) (
  input logic                    clk,
  input logic                    rst,
  serialize_word_to_bits_if.slave bus
);
  localparam int            CW   = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic {
    IDLE,
    SHIFT
  } state_t;

  state_t           state, state_nxt;
  logic [WIDTH-1:0] shift_reg, shift_nxt;
  logic [WIDTH-1:0] hold_reg, hold_nxt;
  logic [CW-1:0]    cnt, cnt_nxt;
  logic             hold_full, hold_full_nxt;
  logic             transfer;
  logic             at_last;
  logic             lead_bit;
  logic [WIDTH-1:0] shifted;

  // Outputs depend only on registered state, never on in_valid/in_data.
  assign bus.in_ready  = !hold_full;
  assign transfer      = bus.in_valid && !hold_full;
  assign at_last       = (cnt == LAST);
  assign lead_bit      = MSB_FIRST ? shift_reg[WIDTH-1] : shift_reg[0];
  assign shifted       = MSB_FIRST ? {shift_reg[WIDTH-2:0], 1'b0}
                                   : {1'b0, shift_reg[WIDTH-1:1]};
  assign bus.out_valid = (state == SHIFT);
  assign bus.out_last  = (state == SHIFT) && at_last;
  assign bus.out_bit   = (state == SHIFT) ? lead_bit : IDLE_BIT;

  always_comb begin
    state_nxt     = state;
    shift_nxt     = shift_reg;
    hold_nxt      = hold_reg;
    cnt_nxt       = cnt;
    hold_full_nxt = hold_full;
    case (state)
      IDLE: begin
        if (transfer) begin
          shift_nxt = bus.in_data;
          cnt_nxt   = '0;
          state_nxt = SHIFT;
        end
      end
      SHIFT: begin
        if (!at_last) begin
          shift_nxt = shifted;
          cnt_nxt   = cnt + CW'(1);
          if (transfer) begin
            hold_nxt      = bus.in_data;
            hold_full_nxt = 1'b1;
          end
        end else if (hold_full) begin
          // Held word takes priority; in_ready is low so no new word arrives now.
          shift_nxt     = hold_reg;
          hold_full_nxt = 1'b0;
          cnt_nxt       = '0;
        end else if (transfer) begin
          shift_nxt = bus.in_data;
          cnt_nxt   = '0;
        end else begin
          shift_nxt = '0;
          cnt_nxt   = '0;
          state_nxt = IDLE;
        end
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      shift_reg <= '0;
      hold_reg  <= '0;
      cnt       <= '0;
      hold_full <= 1'b0;
    end else begin
      state     <= state_nxt;
      shift_reg <= shift_nxt;
      hold_reg  <= hold_nxt;
      cnt       <= cnt_nxt;
      hold_full <= hold_full_nxt;
    end
  end
endmodule

// File: tb/tb_serialize_word_to_bits.sv
// Directed bench for the serializer: an 8-bit MSB-first instance and a 6-bit
// LSB-first instance with IDLE_BIT=1, plus a scoreboarded random run.
module tb_serialize_word_to_bits;
  logic clk;
  logic rst;
  int   test_count;
  int   fail_count;

  serialize_word_to_bits_if #(.WIDTH(8)) bus0 ();
  serialize_word_to_bits_if #(.WIDTH(6)) bus1 ();

  serialize_word_to_bits #(.WIDTH(8), .MSB_FIRST(1'b1), .IDLE_BIT(1'b0)) dut0 (
    .clk (clk),
    .rst (rst),
    .bus (bus0)
  );

  serialize_word_to_bits #(.WIDTH(6), .MSB_FIRST(1'b0), .IDLE_BIT(1'b1)) dut1 (
    .clk (clk),
    .rst (rst),
    .bus (bus1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input int sel, input logic valid, input logic [7:0] data);
    if (sel == 0) begin
      bus0.in_valid = valid;
      bus0.in_data  = data;
    end else begin
      bus1.in_valid = valid;
      bus1.in_data  = data[5:0];
    end
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    test_count++;
    if (observed !== expected) begin
      fail_count++;
      $display("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  initial begin
    logic [15:0] exp16;
    logic [11:0] exp12;
    logic        acc;
    logic [7:0]  rdata;
    int          words;
    int          lasts;
    logic        exp_q[$];

    test_count = 0;
    fail_count = 0;
    rst = 1'b1;
    applyStimulus(0, 1'b0, 8'h00);
    applyStimulus(1, 1'b0, 8'h00);

    // Reset values, during reset and in the cycle after release
    tick();
    checkOutput("rst_rdy0", bus0.in_ready, 1);
    checkOutput("rst_val0", bus0.out_valid, 0);
    checkOutput("rst_last0", bus0.out_last, 0);
    checkOutput("rst_bit0", bus0.out_bit, 0);
    checkOutput("rst_val1", bus1.out_valid, 0);
    checkOutput("rst_bit1", bus1.out_bit, 1);
    rst = 1'b0;
    tick();
    checkOutput("post_rst_rdy0", bus0.in_ready, 1);
    checkOutput("post_rst_val0", bus0.out_valid, 0);
    checkOutput("post_rst_bit1", bus1.out_bit, 1);

    // Two words back to back with in_valid held high: A5 then 3C, gapless
    exp16 = 16'hA53C;
    applyStimulus(0, 1'b1, 8'hA5);
    tick();
    for (int i = 0; i < 16; i++) begin
      checkOutput($sformatf("b2b_val%0d", i), bus0.out_valid, 1);
      checkOutput($sformatf("b2b_bit%0d", i), bus0.out_bit, exp16[15-i]);
      checkOutput($sformatf("b2b_last%0d", i), bus0.out_last, (i == 7 || i == 15) ? 1 : 0);
      checkOutput($sformatf("b2b_rdy%0d", i), bus0.in_ready, (i >= 1 && i <= 7) ? 0 : 1);
      if (i == 0) applyStimulus(0, 1'b1, 8'h3C);
      else        applyStimulus(0, 1'b0, 8'h00);
      tick();
    end
    checkOutput("b2b_end_val", bus0.out_valid, 0);
    checkOutput("b2b_end_bit", bus0.out_bit, 0);
    checkOutput("b2b_end_last", bus0.out_last, 0);

    // LSB-first, 6-bit: 000001 then 111110 offered exactly on the last-bit cycle
    exp12 = 12'b111110000001;
    applyStimulus(1, 1'b1, 8'h01);
    tick();
    applyStimulus(1, 1'b0, 8'h00);
    for (int i = 0; i < 12; i++) begin
      checkOutput($sformatf("byp_val%0d", i), bus1.out_valid, 1);
      checkOutput($sformatf("byp_bit%0d", i), bus1.out_bit, exp12[i]);
      checkOutput($sformatf("byp_last%0d", i), bus1.out_last, (i == 5 || i == 11) ? 1 : 0);
      checkOutput($sformatf("byp_rdy%0d", i), bus1.in_ready, 1);
      if (i == 5) applyStimulus(1, 1'b1, 8'h3E);
      else        applyStimulus(1, 1'b0, 8'h00);
      tick();
    end
    checkOutput("byp_end_val", bus1.out_valid, 0);
    checkOutput("byp_end_bit", bus1.out_bit, 1);
    checkOutput("byp_end_last", bus1.out_last, 0);

    // Reset at bit 3 of FF with 00 held; a word offered with reset is refused
    applyStimulus(0, 1'b1, 8'hFF);
    tick();
    applyStimulus(0, 1'b1, 8'h00);
    tick();
    checkOutput("mid_hold_rdy", bus0.in_ready, 0);
    applyStimulus(0, 1'b0, 8'h00);
    tick();
    tick();
    checkOutput("mid_bit3", bus0.out_bit, 1);
    rst = 1'b1;
    applyStimulus(0, 1'b1, 8'hAA);
    tick();
    checkOutput("mid_rst_val", bus0.out_valid, 0);
    checkOutput("mid_rst_rdy", bus0.in_ready, 1);
    checkOutput("mid_rst_bit", bus0.out_bit, 0);
    rst = 1'b0;
    applyStimulus(0, 1'b0, 8'h00);
    for (int i = 0; i < 16; i++) begin
      tick();
      checkOutput($sformatf("mid_after_val%0d", i), bus0.out_valid, 0);
    end

    // Random traffic against a bit-queue scoreboard
    words = 0;
    lasts = 0;
    for (int c = 0; c < 3000; c++) begin
      rdata = 8'($urandom_range(0, 255));
      applyStimulus(0, ($urandom_range(0, 2) != 0), rdata);
      acc = bus0.in_valid && bus0.in_ready;
      tick();
      if (acc) begin
        words++;
        for (int b = 7; b >= 0; b--) exp_q.push_back(rdata[b]);
      end
      if (bus0.out_valid) begin
        if (bus0.out_last) lasts++;
        if (exp_q.size() == 0) checkOutput("rnd_extra_bit", 1, 0);
        else                   checkOutput("rnd_bit", bus0.out_bit, exp_q.pop_front());
      end
    end
    applyStimulus(0, 1'b0, 8'h00);
    for (int c = 0; c < 40; c++) begin
      tick();
      if (bus0.out_valid) begin
        if (bus0.out_last) lasts++;
        if (exp_q.size() == 0) checkOutput("rnd_extra_bit", 1, 0);
        else                   checkOutput("rnd_bit", bus0.out_bit, exp_q.pop_front());
      end
    end
    checkOutput("rnd_drained", exp_q.size(), 0);
    checkOutput("rnd_last_count", lasts, words);
    checkOutput("rnd_enough_words", (words > 100) ? 1 : 0, 1);

    $display("[TB] %0d tests run, %0d failed", test_count, fail_count);
    $finish;
  end
endmodule

// File: doc/serialize_word_to_bits.md
SERIALIZE_WORD_TO_BITS -- requirements
Module: serialize_word_to_bits

Interface
REQ-001 Parameter: WIDTH, 8, bits per input word; legal range 2..32.
REQ-002 Parameter: MSB_FIRST, 1, bit order; 1 = bit WIDTH-1 first, 0 = bit 0 first.
REQ-003 Parameter: IDLE_BIT, 0, value driven on out_bit while out_valid is 0.
REQ-004 Port: clk  input  1  clock; all state changes on posedge clk.
REQ-005 Port: rst  input  1  reset, synchronous, active-high.
REQ-006 Port: in_valid  input  1  upstream word present.
REQ-007 Port: in_ready  output  1  block can take a word this cycle.
REQ-008 Port: in_data  input  WIDTH  word to serialize.
REQ-009 Port: out_valid  output  1  out_bit carries a data bit this cycle.
REQ-010 Port: out_bit  output  1  serial bit stream, one bit per clock, for the sequence detector.
REQ-011 Port: out_last  output  1  high with the final bit of each word.

Function
REQ-012 Transfer SHALL occur when in_valid && in_ready at a posedge; no other condition captures in_data.
REQ-013 Storage SHALL be a shift register, a bit counter (clog2(WIDTH) bits) and one holding register with a full flag.
REQ-014 in_ready SHALL be !hold_full, combinational from registered state only; no dependence on in_valid.
REQ-015 FSM states SHALL be IDLE (shift register empty) and SHIFT (shift register emitting).
REQ-016 IDLE: on transfer, word loads into the shift register, counter = 0, next state SHIFT; otherwise stay IDLE.
REQ-017 Latency: first bit of an accepted word SHALL appear on out_bit exactly 1 cycle after the transfer when in IDLE.
REQ-018 SHIFT: out_valid = 1; out_bit = current leading bit per MSB_FIRST; counter increments each cycle.
REQ-019 SHIFT, counter < WIDTH-1: a transfer SHALL write the holding register and set hold_full.
REQ-020 SHIFT, counter == WIDTH-1 (out_last = 1), hold_full: holding word moves to the shift register, hold_full cleared, counter = 0, stay SHIFT.
REQ-021 SHIFT, counter == WIDTH-1, hold empty, transfer same cycle: in_data SHALL bypass directly into the shift register, counter = 0, stay SHIFT.
REQ-022 SHIFT, counter == WIDTH-1, hold empty, no transfer: next state IDLE.
REQ-023 REQ-020/021 SHALL give a gapless stream: no out_valid = 0 cycle between consecutive words.
REQ-024 Outside SHIFT: out_valid = 0, out_last = 0, out_bit = IDLE_BIT.
REQ-025 Words SHALL be emitted in acceptance order; none dropped or duplicated.
REQ-026 out_valid, out_bit, out_last SHALL be registered-state outputs with no combinational path from in_valid or in_data.

Reset
REQ-027 rst SHALL force state IDLE, counter 0, hold_full 0, shift register 0.
REQ-028 Output values during reset and the cycle after: in_ready = 1, out_valid = 0, out_last = 0, out_bit = IDLE_BIT.
REQ-029 rst mid-word SHALL discard the partial word and any held word; out_valid = 0 from the next cycle; no bits of discarded words emitted later.
REQ-030 rst SHALL take priority over a simultaneous transfer; that word is not accepted.

Verification
REQ-031 WIDTH=6, MSB_FIRST=1: single word 6'b110011 -> out_bit 1,1,0,0,1,1 on cycles T+1..T+6; out_last only at T+6; out_valid 0 at T+7.
REQ-032 WIDTH=8, in_valid held high with 8'hA5 then 8'h3C -> 16 consecutive valid bits 10100101 00111100; in_ready low while hold full; no gap.
REQ-033 MSB_FIRST=0, WIDTH=8, word 8'h01 -> first bit 1, then seven 0s; IDLE_BIT=1 -> out_bit = 1 whenever out_valid = 0.
REQ-034 Bypass: WIDTH=4, word 4'b1000, second word 4'b0111 offered exactly on the out_last cycle with hold empty -> out_bit 1,0,0,0,0,1,1,1 gapless.
REQ-035 rst asserted at bit 3 of 8'hFF with 8'h00 held -> out_valid 0 next cycle, in_ready 1, neither word's remaining bits ever appear.
REQ-036 Random in_valid over 10,000 cycles vs. scoreboard -> output bit stream equals concatenation of accepted words; every out_last count equals accepted word count.
